// File: rtl/rng_pkg.sv
// Shared types and constants for the arbitrated 16-bit shift-register random source.
package rng_pkg;

    localparam int RNG_LFSR_W = 16;
    localparam int RNG_DATA_W = 4;
    localparam logic [RNG_LFSR_W-1:0] RNG_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        RESP = 2'd2
    } rng_arb_state_t;

    // One generator step: shift left, feed back bit0 ^ bit2.
    function automatic logic [RNG_LFSR_W-1:0] lfsr_next(input logic [RNG_LFSR_W-1:0] cur);
        return {cur[RNG_LFSR_W-2:0], cur[0] ^ cur[2]};
    endfunction

endpackage

// File: rtl/rng_lfsr16.sv
// Generator state register: reset/load/step with load-over-step priority and
// zero-seed substitution so the register can never lock up at all-zero.
module rng_lfsr16
    import rng_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step,
    input  logic                  load,
    input  logic [RNG_LFSR_W-1:0] load_value,
    output logic [RNG_LFSR_W-1:0] lfsr
);

    logic [RNG_LFSR_W-1:0] lfsr_r;
    logic [RNG_LFSR_W-1:0] seed_s;

    // Substitute the default seed for an all-zero load value.
    always_comb begin
        seed_s = load_value;
        if (load_value == {RNG_LFSR_W{1'b0}}) begin
            seed_s = RNG_SEED_DEFAULT;
        end else begin
            seed_s = load_value;
        end
    end

    // Generator state update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= RNG_SEED_DEFAULT;
        end else if (load) begin
            lfsr_r <= seed_s;
        end else if (step) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign lfsr = lfsr_r;

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter granting one generator step per request over valid/ready.
// Optional reseed ports are enabled by defining RNG_ARB_RESEED_EN.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    output logic [N_REQ-1:0]      gnt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [RNG_DATA_W-1:0] rsp_data,
    output logic                  busy
`ifdef RNG_ARB_RESEED_EN
    ,
    input  logic                  seed_load,
    input  logic [RNG_LFSR_W-1:0] seed_value
`endif
);

    rng_arb_state_t        state_r;
    logic [ID_W-1:0]       last_r;
    logic [N_REQ-1:0]      gnt_r;
    logic                  rsp_valid_r;
    logic [ID_W-1:0]       rsp_id_r;
    logic [RNG_DATA_W-1:0] rsp_data_r;
    logic                  busy_r;

    logic [RNG_LFSR_W-1:0] lfsr_s;
    logic                  step_s;
    logic                  load_s;
    logic [RNG_LFSR_W-1:0] load_value_s;
    logic [ID_W-1:0]       winner_s;
    logic                  found_s;

`ifdef RNG_ARB_RESEED_EN
    assign load_s       = seed_load;
    assign load_value_s = seed_value;
`else
    assign load_s       = 1'b0;
    assign load_value_s = RNG_SEED_DEFAULT;
`endif

    // A coinciding seed load pre-empts the step and holds the FSM in GEN.
    assign step_s = (state_r == GEN) && !load_s;

    rng_lfsr16 u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step_s),
        .load       (load_s),
        .load_value (load_value_s),
        .lfsr       (lfsr_s)
    );

    // Round-robin search starting one past the last served requester.
    always_comb begin
        winner_s = last_r;
        found_s  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found_s && req[(int'(last_r) + k) % N_REQ]) begin
                winner_s = ID_W'((int'(last_r) + k) % N_REQ);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Arbitration FSM with registered grant and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            last_r      <= ID_W'(N_REQ - 1);
            gnt_r       <= {N_REQ{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_data_r  <= {RNG_DATA_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        gnt_r    <= {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
                        rsp_id_r <= winner_s;
                        busy_r   <= 1'b1;
                        state_r  <= GEN;
                    end
                end
                GEN: begin
                    if (!load_s) begin
                        rsp_data_r  <= RNG_DATA_W'(lfsr_next(lfsr_s));
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_valid_r && rsp_ready) begin
                        last_r      <= rsp_id_r;
                        gnt_r       <= {N_REQ{1'b0}};
                        rsp_valid_r <= 1'b0;
                        rsp_id_r    <= {ID_W{1'b0}};
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    gnt_r       <= {N_REQ{1'b0}};
                    rsp_valid_r <= 1'b0;
                    rsp_id_r    <= {ID_W{1'b0}};
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter with a queue-free arithmetic reference model.
module tb_rng_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_id;
    logic [3:0] rsp_data;
    logic       busy;
`ifdef RNG_ARB_RESEED_EN
    logic        seed_load;
    logic [15:0] seed_value;
`endif

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] ref_lfsr;
    int          ref_last;

    rng_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
`ifdef RNG_ARB_RESEED_EN
        ,
        .seed_load  (seed_load),
        .seed_value (seed_value)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: value doubled modulo 2^16 plus the parity of bits 0 and 2.
    function automatic logic [15:0] model_step(input logic [15:0] x);
        int v;
        v = int'(x);
        return 16'(((v * 2) % 65536) + ((v ^ (v / 4)) % 2));
    endfunction

    function automatic int model_rr(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req       = 4'h0;
        rsp_ready = 1'b0;
`ifdef RNG_ARB_RESEED_EN
        seed_load  = 1'b0;
        seed_value = 16'h0000;
`endif
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        ref_lfsr = 16'hACE1;
        ref_last = 3;
    endtask

    // Drives one request pattern and collects the response (no checking here).
    task automatic run_txn(input logic [3:0] r, input int stall, output logic got,
                           output int lat, output logic [1:0] id,
                           output logic [3:0] data, output logic [3:0] g);
        req       = r;
        rsp_ready = (stall == 0);
        got = 1'b0; lat = 0; id = 2'd0; data = 4'h0; g = 4'h0;
        for (int c = 1; c <= 12 && !got; c++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                lat = c;
            end
        end
        if (got) begin
            id = rsp_id; data = rsp_data; g = gnt;
            for (int s = 0; s < stall; s++) tick();
            rsp_ready = 1'b1;
            tick();
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_total++; if (gnt !== 4'h0) $display("FAIL reset_gnt: got %h expected 0", gnt); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_id !== 2'd0) $display("FAIL reset_id: got %0d expected 0", rsp_id); else n_pass++;
        n_total++; if (rsp_data !== 4'h0) $display("FAIL reset_data: got %h expected 0", rsp_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (dut.lfsr_s !== 16'hACE1) $display("FAIL reset_lfsr: got %h expected ace1", dut.lfsr_s); else n_pass++;
        tick();
        n_total++; if (dut.lfsr_s !== 16'hACE1) $display("FAIL idle_no_step: got %h expected ace1", dut.lfsr_s); else n_pass++;
    endtask

    task automatic test_first_three;
        logic [3:0] tbl [3];
        logic got; int lat; logic [1:0] id; logic [3:0] data; logic [3:0] g;
        tbl[0] = 4'h3; tbl[1] = 4'h7; tbl[2] = 4'hE;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_txn(4'b0001, 0, got, lat, id, data, g);
            ref_lfsr = model_step(ref_lfsr);
            n_total++; if (!got || lat != 2) $display("FAIL first_latency pass %0d: got %0d expected 2", i, lat); else n_pass++;
            n_total++; if (id !== 2'd0) $display("FAIL first_id pass %0d: got %0d expected 0", i, id); else n_pass++;
            n_total++; if (data !== tbl[i]) $display("FAIL first_data pass %0d: got %h expected %h", i, data, tbl[i]); else n_pass++;
            n_total++; if (dut.lfsr_s !== ref_lfsr) $display("FAIL first_lfsr pass %0d: got %h expected %h", i, dut.lfsr_s, ref_lfsr); else n_pass++;
        end
        req = 4'h0;
    endtask

    task automatic test_all_req;
        int seen = 0;
        int prev = 0;
        int exp_id;
        do_reset();
        req = 4'hF;
        rsp_ready = 1'b1;
        for (int c = 1; c <= 40 && seen < 5; c++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                exp_id   = model_rr(4'hF, ref_last);
                ref_last = exp_id;
                ref_lfsr = model_step(ref_lfsr);
                n_total++; if (rsp_id !== 2'(exp_id)) $display("FAIL all_id pass %0d: got %0d expected %0d", seen, rsp_id, exp_id); else n_pass++;
                n_total++; if (gnt !== 4'(1 << exp_id)) $display("FAIL all_gnt pass %0d: got %b expected %b", seen, gnt, 4'(1 << exp_id)); else n_pass++;
                n_total++; if (rsp_data !== ref_lfsr[3:0]) $display("FAIL all_data pass %0d: got %h expected %h", seen, rsp_data, ref_lfsr[3:0]); else n_pass++;
                if (seen > 0) begin
                    n_total++; if (c - prev != 3) $display("FAIL all_period pass %0d: got %0d expected 3", seen, c - prev); else n_pass++;
                end
                prev = c;
                seen++;
            end
        end
        n_total++; if (seen != 5) $display("FAIL all_count: got %0d expected 5", seen); else n_pass++;
        req = 4'h0;
        tick(); tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic got = 1'b0;
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 12 && !got; c++) begin
            tick();
            got = (rsp_valid === 1'b1);
        end
        n_total++; if (!got) $display("FAIL bp_valid: got 0 expected 1"); else n_pass++;
        req = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_total++; if (rsp_valid !== 1'b1) $display("FAIL bp_hold_valid cyc %0d: got %b expected 1", i, rsp_valid); else n_pass++;
            n_total++; if (rsp_data !== 4'h3) $display("FAIL bp_hold_data cyc %0d: got %h expected 3", i, rsp_data); else n_pass++;
            n_total++; if (rsp_id !== 2'd0) $display("FAIL bp_hold_id cyc %0d: got %0d expected 0", i, rsp_id); else n_pass++;
            n_total++; if (gnt !== 4'b0001) $display("FAIL bp_hold_gnt cyc %0d: got %b expected 0001", i, gnt); else n_pass++;
            n_total++; if (dut.lfsr_s !== 16'h59C3) $display("FAIL bp_hold_lfsr cyc %0d: got %h expected 59c3", i, dut.lfsr_s); else n_pass++;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL bp_release_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_total++; if (gnt !== 4'h0) $display("FAIL bp_release_gnt: got %b expected 0", gnt); else n_pass++;
    endtask

    task automatic test_drop_req;
        logic got = 1'b0;
        logic g2; int lat; logic [1:0] id; logic [3:0] data; logic [3:0] g;
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 12 && !got; c++) begin
            tick();
            got = (rsp_valid === 1'b1);
        end
        id = rsp_id; data = rsp_data;
        req = 4'b0010;
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        ref_lfsr = model_step(ref_lfsr);
        n_total++; if (!got || id !== 2'd0) $display("FAIL drop_id: got %0d expected 0", id); else n_pass++;
        n_total++; if (data !== ref_lfsr[3:0]) $display("FAIL drop_data: got %h expected %h", data, ref_lfsr[3:0]); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL drop_done: got busy %b expected 0", busy); else n_pass++;
        run_txn(4'b0011, 0, g2, lat, id, data, g);
        ref_lfsr = model_step(ref_lfsr);
        n_total++; if (!g2 || id !== 2'd1) $display("FAIL drop_next_id: got %0d expected 1", id); else n_pass++;
        n_total++; if (data !== ref_lfsr[3:0]) $display("FAIL drop_next_data: got %h expected %h", data, ref_lfsr[3:0]); else n_pass++;
        req = 4'h0;
    endtask

    task automatic test_reset_mid;
        logic got = 1'b0;
        int lat; logic [1:0] id; logic [3:0] data; logic [3:0] g;
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 12 && !got; c++) begin
            tick();
            got = (rsp_valid === 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_total++; if (gnt !== 4'h0) $display("FAIL midrst_gnt: got %b expected 0", gnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
        do_reset();
        run_txn(4'b0001, 0, got, lat, id, data, g);
        n_total++; if (!got || data !== 4'h3) $display("FAIL midrst_after_data: got %h expected 3", data); else n_pass++;
        req = 4'h0;
    endtask

    task automatic test_random;
        logic got; int lat; logic [1:0] id; logic [3:0] data; logic [3:0] g;
        logic [3:0] r;
        int st, exp_id;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            r  = 4'($urandom_range(1, 15));
            st = $urandom_range(0, 3);
            run_txn(r, st, got, lat, id, data, g);
            exp_id   = model_rr(r, ref_last);
            ref_last = exp_id;
            ref_lfsr = model_step(ref_lfsr);
            n_total++; if (!got || lat != 2) $display("FAIL rand_latency txn %0d: got %0d expected 2", i, lat); else n_pass++;
            n_total++; if (id !== 2'(exp_id)) $display("FAIL rand_id txn %0d req %b: got %0d expected %0d", i, r, id, exp_id); else n_pass++;
            n_total++; if (data !== ref_lfsr[3:0]) $display("FAIL rand_data txn %0d: got %h expected %h", i, data, ref_lfsr[3:0]); else n_pass++;
            n_total++; if (g !== 4'(1 << exp_id)) $display("FAIL rand_gnt txn %0d: got %b expected %b", i, g, 4'(1 << exp_id)); else n_pass++;
        end
        req = 4'h0;
    endtask

`ifdef RNG_ARB_RESEED_EN
    task automatic test_reseed;
        logic got; int lat; logic [1:0] id; logic [3:0] data; logic [3:0] g;
        do_reset();
        run_txn(4'b0001, 0, got, lat, id, data, g);
        req = 4'h0;
        seed_value = 16'h0000;
        seed_load  = 1'b1;
        tick();
        seed_load  = 1'b0;
        ref_lfsr = model_step(16'hACE1);
        run_txn(4'b0001, 0, got, lat, id, data, g);
        n_total++; if (!got || data !== ref_lfsr[3:0]) $display("FAIL seed_zero_data: got %h expected %h", data, ref_lfsr[3:0]); else n_pass++;
        req = 4'b0001;
        rsp_ready = 1'b1;
        tick();
        seed_value = 16'h0001;
        seed_load  = 1'b1;
        tick();
        seed_load  = 1'b0;
        n_total++; if (rsp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL seed_gen_hold: got valid %b busy %b expected 0 1", rsp_valid, busy); else n_pass++;
        tick();
        ref_lfsr = model_step(16'h0001);
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL seed_gen_valid: got %b expected 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== ref_lfsr[3:0]) $display("FAIL seed_gen_data: got %h expected %h", rsp_data, ref_lfsr[3:0]); else n_pass++;
        n_total++; if (dut.lfsr_s !== ref_lfsr) $display("FAIL seed_gen_lfsr: got %h expected %h", dut.lfsr_s, ref_lfsr); else n_pass++;
        req = 4'h0;
        tick();
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_first_three();
        test_all_req();
        test_backpressure();
        test_drop_req();
        test_reset_mid();
        test_random();
`ifdef RNG_ARB_RESEED_EN
        test_reseed();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
